rr_mux: RTL and testbench

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux_pkg.sv | 13 +
 rtl/rr_arb.sv | 27 ++
 rtl/rr_mux.sv | 90 +++++++++
 tb/tb_rr_mux.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the rr_mux round-robin / forced-select multiplexer.
// Holds the mode encoding and the default channel count and word width.
package rr_mux_pkg;

  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_SEL = 1'b1
  } mode_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/rr_arb.sv
// Combinational rotating-priority picker: the first asserted request
// at or after ptr (wrapping around) wins the grant.
module rr_arb #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_CH;
      if (req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 channel multiplexer with a one-word output register, selecting either
// by rotating priority or by an externally forced channel index.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH-1:0]        i_valid,
  output logic [NUM_CH-1:0]        o_ready,
  input  logic                     i_mode,
  input  logic [SEL_W-1:0]         i_sel,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [SEL_W-1:0]         o_grant
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_grant_valid;
  logic [SEL_W-1:0]  grant;
  logic              grant_valid;
  logic [NUM_CH-1:0] sel_vec;
  logic              sel_in_range;
  logic              le;
  logic              ch_xfer;
  logic [DATA_W-1:0] sel_word;
  logic [SEL_W-1:0]  ptr_next;

  rr_arb #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req         (i_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  // Shift instead of indexing so a non-power-of-two channel count never reads past i_valid.
  assign sel_vec      = i_valid >> i_sel;
  assign sel_in_range = int'(i_sel) < NUM_CH;

  always_comb begin
    if (mode_e'(i_mode) == MODE_SEL) begin
      grant       = i_sel;
      grant_valid = sel_in_range && sel_vec[0];
    end else begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end
  end

  assign le       = !o_valid || i_ready;
  assign ch_xfer  = le && grant_valid && !i_rst;
  assign sel_word = i_data[int'(grant)*DATA_W +: DATA_W];
  assign ptr_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_xfer && int'(grant) == k) begin
        o_ready[k] = 1'b1;
      end
    end
  end

  // A new word may replace the held one on the same edge it leaves, giving one word per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_grant <= '0;
      ptr     <= '0;
    end else if (ch_xfer) begin
      o_valid <= 1'b1;
      o_data  <= sel_word;
      o_grant <= grant;
      ptr     <= ptr_next;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux with four 4-bit channels;
// every expected value below is worked out by hand from the intended behaviour.
module tb_rr_mux;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  ready_out;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  data_out;
  logic        valid_out;
  logic        ready_in;
  logic [1:0]  grant_out;

  int checks = 0;
  int errors = 0;

  rr_mux #(
    .NUM_CH (4),
    .DATA_W (4)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (data_in),
    .i_valid (valid_in),
    .o_ready (ready_out),
    .i_mode  (mode),
    .i_sel   (sel),
    .o_data  (data_out),
    .o_valid (valid_out),
    .i_ready (ready_in),
    .o_grant (grant_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic rdy,
                               input logic m, input logic [1:0] s, input logic [15:0] d);
    rst      = r;
    valid_in = v;
    ready_in = rdy;
    mode     = m;
    sel      = s;
    data_in  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with every channel requesting.
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 16'h4321);
    cycle();
    cycle();
    checkOutput("reset_valid", 32'(valid_out), 32'h0);
    checkOutput("reset_data", 32'(data_out), 32'h0);
    checkOutput("reset_grant", 32'(grant_out), 32'h0);
    checkOutput("reset_ready", 32'(ready_out), 32'h0);

    // Round-robin across all four channels.
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 16'h4321);
    #1;
    checkOutput("rr_first_ready", 32'(ready_out), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("rr_valid", 32'(valid_out), 32'h1);
      checkOutput("rr_grant", 32'(grant_out), 32'(i % 4));
      checkOutput("rr_data", 32'(data_out), 32'((i % 4) + 1));
    end
    cycle();
    checkOutput("rr_data_2", 32'(data_out), 32'h2);

    // Backpressure while the word 2 is held.
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 16'h4321);
    #1;
    checkOutput("bp_ready_stall", 32'(ready_out), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("bp_data", 32'(data_out), 32'h2);
      checkOutput("bp_valid", 32'(valid_out), 32'h1);
      checkOutput("bp_grant", 32'(grant_out), 32'h1);
      checkOutput("bp_ready", 32'(ready_out), 32'h0);
    end
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 16'h4321);
    #1;
    checkOutput("bp_release_ready", 32'(ready_out), 32'b0100);
    cycle();
    checkOutput("bp_release_data", 32'(data_out), 32'h3);
    checkOutput("bp_release_grant", 32'(grant_out), 32'h2);

    // Wrap-around with only channels 0 and 3 requesting.
    applyStimulus(1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 16'h4321);
    #1;
    checkOutput("wrap_ready", 32'(ready_out), 32'b1000);
    cycle();
    checkOutput("wrap_grant_a", 32'(grant_out), 32'h3);
    checkOutput("wrap_data_a", 32'(data_out), 32'h4);
    cycle();
    checkOutput("wrap_grant_b", 32'(grant_out), 32'h0);
    checkOutput("wrap_data_b", 32'(data_out), 32'h1);
    cycle();
    checkOutput("wrap_grant_c", 32'(grant_out), 32'h3);

    // Forced select of channel 2.
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 16'h4A21);
    #1;
    checkOutput("sel_ready", 32'(ready_out), 32'b0100);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checkOutput("sel_grant", 32'(grant_out), 32'h2);
      checkOutput("sel_data", 32'(data_out), 32'hA);
      checkOutput("sel_valid", 32'(valid_out), 32'h1);
    end
    applyStimulus(1'b0, 4'b1011, 1'b1, 1'b1, 2'd2, 16'h4A21);
    #1;
    checkOutput("sel_idle_ready", 32'(ready_out), 32'h0);
    cycle();
    checkOutput("sel_idle_valid", 32'(valid_out), 32'h0);
    checkOutput("sel_idle_data_hold", 32'(data_out), 32'hA);
    checkOutput("sel_idle_grant_hold", 32'(grant_out), 32'h2);
    cycle();
    checkOutput("sel_idle_valid_2", 32'(valid_out), 32'h0);

    // Reset in the middle of a stalled word; pointer was left at 3.
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 16'h4321);
    #1;
    checkOutput("mid_ready_pre", 32'(ready_out), 32'b1000);
    cycle();
    checkOutput("mid_grant_pre", 32'(grant_out), 32'h3);
    checkOutput("mid_data_pre", 32'(data_out), 32'h4);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 16'h4321);
    #1;
    checkOutput("mid_rst_ready", 32'(ready_out), 32'h0);
    cycle();
    checkOutput("mid_rst_valid", 32'(valid_out), 32'h0);
    checkOutput("mid_rst_data", 32'(data_out), 32'h0);
    checkOutput("mid_rst_grant", 32'(grant_out), 32'h0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 16'h4321);
    #1;
    checkOutput("mid_post_ready", 32'(ready_out), 32'b0001);
    cycle();
    checkOutput("mid_post_grant", 32'(grant_out), 32'h0);
    checkOutput("mid_post_data", 32'(data_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
